// File: rtl/operand_forward.sv
// operand_forward: execute-stage operand register of the 4-stage pipeline.
// Selects each source operand (regfile / in-flight ALU result / write-back
// data) from the registered hazard codes and launches the pair into execute
// behind a valid/ready handshake. Owns flush and the one-cycle load-use
// interlock.
// Build option: define OPFWD_LOADUSE_EN to enable the load-use interlock
// (LU_WAIT state, lu_stall). Undefined: loads are assumed to complete in EX,
// code 01 always selects alu_result and lu_stall is tied low.
module operand_forward #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [1:0]      rs1_hazard,
  input  logic [1:0]      rs2_hazard,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] memtoreg_data_DH,
  input  logic            fwd_src_is_load,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic            lu_stall
);

  logic            lu_hit;
  logic            accept;
  logic [1:0]      rs1_code;
  logic [1:0]      rs2_code;
  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;

  // Source mux: 01 ALU result, 10 write-back data, 00/11 register file.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [1:0]      code,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] wb
  );
    logic [XLEN-1:0] res;
    case (code)
      2'b01:   res = alu;
      2'b10:   res = wb;
      default: res = rf;
    endcase
    return res;
  endfunction

`ifdef OPFWD_LOADUSE_EN
  typedef enum logic {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // A load in EX whose result is needed by an operand of the decode
  // instruction; only detected in RUN so the held instruction never re-stalls.
  assign lu_hit = (state == RUN) && id_valid && fwd_src_is_load &&
                  ((rs1_hazard == 2'b01) || (rs2_hazard == 2'b01));

  // Interlock state register; lu_stall mirrors LU_WAIT as a registered flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RUN;
      lu_stall <= 1'b0;
    end else begin
      state    <= state_next;
      lu_stall <= (state_next == LU_WAIT);
    end
  end

  // Next state: flush wins; enter LU_WAIT only when the bubble can actually
  // drain into execute, leave once the held instruction is accepted.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN:     if (lu_hit && (!ex_valid || ex_ready)) state_next = LU_WAIT;
        LU_WAIT: if (accept) state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  // While waiting, the load result has moved to the write-back path, so any
  // ALU-forward code of the held instruction is redirected there.
  always_comb begin
    rs1_code = rs1_hazard;
    rs2_code = rs2_hazard;
    if (state == LU_WAIT) begin
      if (rs1_hazard == 2'b01) rs1_code = 2'b10;
      if (rs2_hazard == 2'b01) rs2_code = 2'b10;
    end
  end
`else
  logic unused_fwd_src_is_load;

  assign unused_fwd_src_is_load = fwd_src_is_load;
  assign lu_hit                 = 1'b0;
  assign lu_stall               = 1'b0;
  assign rs1_code               = rs1_hazard;
  assign rs2_code               = rs2_hazard;
`endif

  assign op1_sel  = pick_operand(rs1_code, rf_rdata1, alu_result, memtoreg_data_DH);
  assign op2_sel  = pick_operand(rs2_code, rf_rdata2, alu_result, memtoreg_data_DH);

  assign id_ready = !flush && (!ex_valid || ex_ready) && !lu_hit;
  assign accept   = id_valid && id_ready;

  // Output register: flush kills, accept loads, drain without refill clears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid <= 1'b0;
      ex_op1   <= '0;
      ex_op2   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_op1   <= op1_sel;
      ex_op2   <= op2_sel;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_forward.sv
// Testbench for operand_forward: directed scenarios plus randomized traffic
// against a cycle-level reference model of the handshake/forwarding rules.
// Honours OPFWD_LOADUSE_EN the same way the design does.
module tb_operand_forward;

  localparam int unsigned XLEN = 32;
`ifdef OPFWD_LOADUSE_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            id_valid = 1'b0;
  logic            id_ready;
  logic [1:0]      rs1_hazard = '0;
  logic [1:0]      rs2_hazard = '0;
  logic [XLEN-1:0] rf_rdata1 = '0;
  logic [XLEN-1:0] rf_rdata2 = '0;
  logic [XLEN-1:0] alu_result = '0;
  logic [XLEN-1:0] memtoreg_data_DH = '0;
  logic            fwd_src_is_load = 1'b0;
  logic            flush = 1'b0;
  logic            ex_ready = 1'b1;
  logic            ex_valid;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic            lu_stall;

  always #5 clk = ~clk;

  operand_forward #(.XLEN(XLEN)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .rs1_hazard      (rs1_hazard),
    .rs2_hazard      (rs2_hazard),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .alu_result      (alu_result),
    .memtoreg_data_DH(memtoreg_data_DH),
    .fwd_src_is_load (fwd_src_is_load),
    .flush           (flush),
    .ex_ready        (ex_ready),
    .ex_valid        (ex_valid),
    .ex_op1          (ex_op1),
    .ex_op2          (ex_op2),
    .lu_stall        (lu_stall)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what execute holds, and whether the decode instruction
  // has already paid its load-use bubble.
  bit          m_valid = 1'b0;
  bit          m_wait  = 1'b0;
  logic [31:0] m_op1   = '0;
  logic [31:0] m_op2   = '0;

  function automatic bit m_lu_hit();
    return LU_EN && !m_wait && id_valid && fwd_src_is_load &&
           (rs1_hazard == 2'b01 || rs2_hazard == 2'b01);
  endfunction

  function automatic bit m_ready();
    return !flush && (!m_valid || ex_ready) && !m_lu_hit();
  endfunction

  function automatic logic [31:0] m_pick(input logic [1:0] code, input logic [31:0] rf);
    if (code == 2'b01) return m_wait ? memtoreg_data_DH : alu_result;
    if (code == 2'b10) return memtoreg_data_DH;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_wait  = 1'b0;
    m_op1   = '0;
    m_op2   = '0;
  endtask

  // One clock: evaluate the model on pre-edge inputs, advance it at the edge.
  task automatic tick();
    bit          hit;
    bit          rdy;
    logic [31:0] n1;
    logic [31:0] n2;
    hit = m_lu_hit();
    rdy = m_ready();
    n1  = m_pick(rs1_hazard, rf_rdata1);
    n2  = m_pick(rs2_hazard, rf_rdata2);
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else if (flush) begin
      m_valid = 1'b0;
      m_wait  = 1'b0;
    end else if (id_valid && rdy) begin
      m_valid = 1'b1;
      m_wait  = 1'b0;
      m_op1   = n1;
      m_op2   = n2;
    end else begin
      if (hit && (!m_valid || ex_ready)) m_wait = 1'b1;
      if (ex_ready) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic set_instr(input bit v, input logic [1:0] c1, input logic [1:0] c2,
                           input logic [31:0] r1, input logic [31:0] r2, input bit ld);
    id_valid        = v;
    rs1_hazard      = c1;
    rs2_hazard      = c2;
    rf_rdata1       = r1;
    rf_rdata2       = r2;
    fwd_src_is_load = ld;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_instr(1'b1, 2'b00, 2'b00, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0);
    ex_ready = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (ex_valid !== 1'b0 || ex_op1 !== '0 || ex_op2 !== '0 || lu_stall !== 1'b0)
        $display("FAIL reset_state: ex_valid=%0b op1=%h op2=%h lu_stall=%0b, want 0/0/0/0",
                 ex_valid, ex_op1, ex_op2, lu_stall);
      else n_pass++;
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 32'hAAAA_0001 || ex_op2 !== 32'hBBBB_0002)
      $display("FAIL reset_first_accept: ex_valid=%0b op1=%h op2=%h, want 1/aaaa0001/bbbb0002",
               ex_valid, ex_op1, ex_op2);
    else n_pass++;
  endtask

  task automatic test_select();
    set_instr(1'b1, 2'b00, 2'b01, 32'h11, 32'h99, 1'b0);
    alu_result = 32'h22;
    ex_ready   = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) $display("FAIL sel_ready: id_ready=%0b, want 1", id_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 32'h11 || ex_op2 !== 32'h22)
      $display("FAIL sel_rf_alu: ex_valid=%0b op1=%h op2=%h, want 1/11/22", ex_valid, ex_op1, ex_op2);
    else n_pass++;
    set_instr(1'b1, 2'b10, 2'b11, 32'h77, 32'h5, 1'b0);
    memtoreg_data_DH = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 32'hDEAD_BEEF || ex_op2 !== 32'h5)
      $display("FAIL sel_wb_rsvd: ex_valid=%0b op1=%h op2=%h, want 1/deadbeef/5", ex_valid, ex_op1, ex_op2);
    else n_pass++;
  endtask

  task automatic test_load_use();
    logic [1:0]  c1;
    logic [1:0]  c2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    for (int i = 0; i < 3; i++) begin
      c1 = (i != 1) ? 2'b01 : 2'b00;
      c2 = (i != 0) ? 2'b01 : 2'b00;
      set_instr(1'b1, c1, c2, 32'h1000 + i, 32'h2000 + i, 1'b1);
      alu_result       = 32'h22;
      memtoreg_data_DH = 32'h0;
      ex_ready         = 1'b1;
      flush            = 1'b0;
      #1;
`ifdef OPFWD_LOADUSE_EN
      n_checks++;
      if (id_ready !== 1'b0) $display("FAIL lu_ready_low[%0d]: id_ready=%0b, want 0", i, id_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (ex_valid !== 1'b0 || lu_stall !== 1'b1)
        $display("FAIL lu_bubble[%0d]: ex_valid=%0b lu_stall=%0b, want 0/1", i, ex_valid, lu_stall);
      else n_pass++;
      memtoreg_data_DH = 32'hCAFE_0001;
      #1;
      n_checks++;
      if (id_ready !== 1'b1) $display("FAIL lu_ready_wait[%0d]: id_ready=%0b, want 1", i, id_ready);
      else n_pass++;
      tick();
      exp1 = (c1 == 2'b01) ? 32'hCAFE_0001 : 32'h1000 + i;
      exp2 = (c2 == 2'b01) ? 32'hCAFE_0001 : 32'h2000 + i;
`else
      n_checks++;
      if (id_ready !== 1'b1) $display("FAIL lu_off_ready[%0d]: id_ready=%0b, want 1", i, id_ready);
      else n_pass++;
      tick();
      exp1 = (c1 == 2'b01) ? 32'h22 : 32'h1000 + i;
      exp2 = (c2 == 2'b01) ? 32'h22 : 32'h2000 + i;
`endif
      n_checks++;
      if (ex_valid !== 1'b1 || ex_op1 !== exp1 || ex_op2 !== exp2 || lu_stall !== 1'b0)
        $display("FAIL lu_capture[%0d]: ex_valid=%0b op1=%h op2=%h lu_stall=%0b, want 1/%h/%h/0",
                 i, ex_valid, ex_op1, ex_op2, lu_stall, exp1, exp2);
      else n_pass++;
    end
    set_instr(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    set_instr(1'b1, 2'b00, 2'b00, 32'hA1, 32'hA2, 1'b0);
    ex_ready = 1'b1;
    tick();
    set_instr(1'b1, 2'b00, 2'b00, 32'hB1, 32'hB2, 1'b0);
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (id_ready !== 1'b0) $display("FAIL bp_ready[%0d]: id_ready=%0b, want 0", k, id_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (ex_valid !== 1'b1 || ex_op1 !== 32'hA1 || ex_op2 !== 32'hA2)
        $display("FAIL bp_hold[%0d]: ex_valid=%0b op1=%h op2=%h, want 1/a1/a2", k, ex_valid, ex_op1, ex_op2);
      else n_pass++;
    end
    ex_ready = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) $display("FAIL b2b_ready: id_ready=%0b, want 1", id_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 32'hB1 || ex_op2 !== 32'hB2)
      $display("FAIL b2b_accept: ex_valid=%0b op1=%h op2=%h, want 1/b1/b2", ex_valid, ex_op1, ex_op2);
    else n_pass++;
    id_valid = 1'b0;
    tick();
    n_checks++;
    if (ex_valid !== 1'b0) $display("FAIL drain_clear: ex_valid=%0b, want 0", ex_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    ex_ready = 1'b1;
`ifdef OPFWD_LOADUSE_EN
    set_instr(1'b1, 2'b01, 2'b00, 32'hF1, 32'hF2, 1'b1);
    tick();
    n_checks++;
    if (lu_stall !== 1'b1) $display("FAIL flush_enter_wait: lu_stall=%0b, want 1", lu_stall);
    else n_pass++;
`else
    set_instr(1'b1, 2'b00, 2'b00, 32'hF1, 32'hF2, 1'b0);
    tick();
`endif
    flush = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b0) $display("FAIL flush_ready: id_ready=%0b, want 0", id_ready);
    else n_pass++;
    tick();
    flush = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b0 || lu_stall !== 1'b0)
      $display("FAIL flush_kill: ex_valid=%0b lu_stall=%0b, want 0/0", ex_valid, lu_stall);
    else n_pass++;
`ifdef OPFWD_LOADUSE_EN
    // Back in RUN, the same load-use pair must be detected afresh.
    #1;
    n_checks++;
    if (id_ready !== 1'b0) $display("FAIL flush_back_to_run: id_ready=%0b, want 0", id_ready);
    else n_pass++;
`endif
    set_instr(1'b1, 2'b00, 2'b00, 32'hE1, 32'hE2, 1'b0);
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 32'hE1 || ex_op2 !== 32'hE2)
      $display("FAIL flush_resume: ex_valid=%0b op1=%h op2=%h, want 1/e1/e2", ex_valid, ex_op1, ex_op2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_instr(1'b1, 2'b01, 2'b00, 32'hC1, 32'hC2, 1'b1);
    ex_ready = 1'b1;
    tick();
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (ex_valid !== 1'b0 || lu_stall !== 1'b0 || ex_op1 !== '0)
      $display("FAIL async_reset: ex_valid=%0b lu_stall=%0b op1=%h, want 0/0/0", ex_valid, lu_stall, ex_op1);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    set_instr(1'b1, 2'b00, 2'b10, 32'hD1, 32'hD2, 1'b0);
    memtoreg_data_DH = 32'h1234_5678;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_op1 !== 32'hD1 || ex_op2 !== 32'h1234_5678)
      $display("FAIL reset_mid_resume: ex_valid=%0b op1=%h op2=%h, want 1/d1/12345678",
               ex_valid, ex_op1, ex_op2);
    else n_pass++;
  endtask

  task automatic test_random();
    bit hold;
    bit exp_rdy;
    hold = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!hold) begin
        id_valid        = ($urandom_range(0, 3) != 0);
        rs1_hazard      = 2'($urandom);
        rs2_hazard      = 2'($urandom);
        rf_rdata1       = $urandom;
        rf_rdata2       = $urandom;
        fwd_src_is_load = ($urandom_range(0, 2) == 0);
      end
      alu_result       = $urandom;
      memtoreg_data_DH = $urandom;
      ex_ready         = ($urandom_range(0, 3) != 0);
      flush            = ($urandom_range(0, 15) == 0);
      #1;
      exp_rdy = m_ready();
      n_checks++;
      if (id_ready !== exp_rdy) $display("FAIL rnd_ready[%0d]: id_ready=%0b, want %0b", c, id_ready, exp_rdy);
      else n_pass++;
      hold = id_valid && !exp_rdy && !flush;
      tick();
      n_checks++;
      if (ex_valid !== m_valid || lu_stall !== m_wait)
        $display("FAIL rnd_ctrl[%0d]: ex_valid=%0b lu_stall=%0b, want %0b/%0b",
                 c, ex_valid, lu_stall, m_valid, m_wait);
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if (ex_op1 !== m_op1 || ex_op2 !== m_op2)
          $display("FAIL rnd_ops[%0d]: op1=%h op2=%h, want %h/%h", c, ex_op1, ex_op2, m_op1, m_op2);
        else n_pass++;
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_select();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
